hex_byte_sequencer: RTL and testbench

Sequencer that sits directly upstream of the board's two seven-segment hex converters. It accepts 32-bit words (typically a bus address or read-data value) on a valid/ready handshake and buffers them in a small FIFO. It then presents each word one byte at a time as a high/low nibble pair, holding each byte for a programmable number of slow-clock cycles so a human can read the full word on two digits.

---
 rtl/hex_byte_sequencer_pkg.sv | 35 +++
 rtl/hex_byte_sequencer_if.sv | 26 ++
 rtl/hex_seq_fifo.sv | 48 ++++
 rtl/hex_byte_sequencer.sv | 145 ++++++++++++++
 tb/tb_hex_byte_sequencer.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/hex_byte_sequencer_pkg.sv
// Shared types and helpers for the hex byte sequencer.
package hex_seq_pkg;

    localparam int unsigned WORD_W  = 32;
    localparam int unsigned BYTE_W  = 8;
    localparam int unsigned NIB_W   = 4;
    localparam int unsigned IDX_W   = 2;
    localparam int unsigned MSB_IDX = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SHOW = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    // Nibble pair driven to the two hex converters
    typedef struct packed {
        logic [NIB_W-1:0] hi;
        logic [NIB_W-1:0] lo;
    } nib_pair_t;

    // Hold counter runs 0..hold-1; keep at least one bit
    function automatic int unsigned hold_cnt_w(input int unsigned hold);
        return (hold <= 1) ? 1 : $clog2(hold);
    endfunction

    // Split byte[idx] of a word into its two nibbles
    function automatic nib_pair_t pick_byte(input logic [WORD_W-1:0] w,
                                            input logic [IDX_W-1:0]  idx);
        logic [WORD_W-1:0] s;
        s = w >> {idx, 3'b000};
        return nib_pair_t'(s[BYTE_W-1:0]);
    endfunction

endpackage

// File: rtl/hex_byte_sequencer_if.sv
// Producer handshake plus display outputs of the hex byte sequencer.
interface hex_byte_sequencer_if;

    logic                            in_valid;
    logic [hex_seq_pkg::WORD_W-1:0]  in_data;
    logic                            in_ready;
    logic [hex_seq_pkg::NIB_W-1:0]   hi_nibble;
    logic [hex_seq_pkg::NIB_W-1:0]   lo_nibble;
    logic [hex_seq_pkg::IDX_W-1:0]   byte_idx;
    logic                            blank;
    logic                            busy;
    logic                            overflow;

    // Producer / observer side
    modport master (
        output in_valid, in_data,
        input  in_ready, hi_nibble, lo_nibble, byte_idx, blank, busy, overflow
    );

    // Sequencer side
    modport slave (
        input  in_valid, in_data,
        output in_ready, hi_nibble, lo_nibble, byte_idx, blank, busy, overflow
    );

endinterface

// File: rtl/hex_seq_fifo.sv
// Synchronous word FIFO with wrap-bit pointers; async active-high reset.
module hex_seq_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wr_data,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];

    logic do_push;
    logic do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Pointer update; the extra MSB distinguishes full from empty
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    // Storage write; contents need no reset since pointers gate visibility
    always_ff @(posedge CLK) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head  = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/hex_byte_sequencer.sv
// Buffers 32-bit words and shows them MSB byte first as nibble pairs,
// each byte held HOLD_CYCLES cycles. Define HEX_SEQ_GAP_EN to insert a
// blanked separator of HOLD_CYCLES cycles after every word.
module hex_byte_sequencer
    import hex_seq_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES = 8,
    parameter int unsigned FIFO_DEPTH  = 4
) (
    input  logic                  CLK,
    input  logic                  RESET,
    hex_byte_sequencer_if.slave   bus
);

    localparam int unsigned      CNT_W    = hold_cnt_w(HOLD_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_CYCLES - 1);

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [WORD_W-1:0]   word_q, word_d;
    nib_pair_t           nib_q, nib_d;
    logic                blank_q, blank_d;
    logic                overflow_q;

    logic                fifo_full;
    logic                fifo_empty;
    logic [WORD_W-1:0]   fifo_head;
    logic                push;
    logic                pop;
    logic                word_end;

    assign push = bus.in_valid && !fifo_full;

    hex_seq_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (WORD_W)
    ) u_fifo (
        .CLK     (CLK),
        .RESET   (RESET),
        .push    (push),
        .pop     (pop),
        .wr_data (bus.in_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .head    (fifo_head)
    );

    // State, counter, shift register and display registers
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            word_q  <= '0;
            nib_q   <= '0;
            blank_q <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            word_q  <= word_d;
            nib_q   <= nib_d;
            blank_q <= blank_d;
        end
    end

    // Next-state: byte stepping, optional gap, word-end pop-or-idle decision
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        word_d   = word_q;
        blank_d  = blank_q;
        pop      = 1'b0;
        word_end = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                blank_d = 1'b1;
                if (!fifo_empty) word_end = 1'b1;
            end
            ST_SHOW: begin
                if (cnt_q == CNT_LAST) begin
                    if (idx_q != '0) begin
                        idx_d = idx_q - IDX_W'(1);
                        cnt_d = '0;
                    end else begin
`ifdef HEX_SEQ_GAP_EN
                        state_d = ST_GAP;
                        cnt_d   = '0;
                        blank_d = 1'b1;
`else
                        word_end = 1'b1;
`endif
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
`ifdef HEX_SEQ_GAP_EN
            ST_GAP: begin
                if (cnt_q == CNT_LAST) word_end = 1'b1;
                else                   cnt_d    = cnt_q + CNT_W'(1);
            end
`endif
            default: begin
                state_d = ST_IDLE;
                blank_d = 1'b1;
            end
        endcase

        // Load the next word straight into SHOW, or fall back to IDLE
        if (word_end) begin
            if (!fifo_empty) begin
                pop     = 1'b1;
                word_d  = fifo_head;
                idx_d   = IDX_W'(MSB_IDX);
                cnt_d   = '0;
                state_d = ST_SHOW;
                blank_d = 1'b0;
            end else begin
                state_d = ST_IDLE;
                blank_d = 1'b1;
            end
        end

        nib_d = pick_byte(word_d, idx_d);
    end

    // Sticky overflow on any offer while full
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET)                              overflow_q <= 1'b0;
        else if (bus.in_valid && fifo_full)     overflow_q <= 1'b1;
    end

    assign bus.in_ready  = !fifo_full;
    assign bus.busy      = (state_q != ST_IDLE) || !fifo_empty;
    assign bus.hi_nibble = nib_q.hi;
    assign bus.lo_nibble = nib_q.lo;
    assign bus.byte_idx  = idx_q;
    assign bus.blank     = blank_q;
    assign bus.overflow  = overflow_q;

endmodule

// File: tb/tb_hex_byte_sequencer.sv
// Randomised + directed bench for hex_byte_sequencer against a
// time-based behavioural model of the word display.
module tb_hex_byte_sequencer;

    localparam int H = 2;
    localparam int D = 4;
`ifdef HEX_SEQ_GAP_EN
    localparam int PERIOD = 5 * H;
`else
    localparam int PERIOD = 4 * H;
`endif

    logic clk;
    logic rst;
    int   tests;
    int   fails;
    bit   seen_drop;

    hex_byte_sequencer_if bus ();

    hex_byte_sequencer #(
        .HOLD_CYCLES (H),
        .FIFO_DEPTH  (D)
    ) dut (
        .CLK   (clk),
        .RESET (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    logic [31:0] mq[$];
    bit          m_active;
    int          m_t;
    logic [31:0] m_cur;
    bit          m_ovf;

    initial begin
        mq.delete();
        m_active = 0; m_t = 0; m_cur = 0; m_ovf = 0;
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                mq.delete();
                m_active = 0; m_t = 0; m_cur = 0; m_ovf = 0;
            end else begin
                bit had, full;
                had  = (mq.size() > 0);
                full = (mq.size() == D);
                if (bus.in_valid && full) m_ovf = 1;
                if (!m_active) begin
                    if (had) begin m_cur = mq.pop_front(); m_active = 1; m_t = 0; end
                end else begin
                    m_t++;
                    if (m_t == PERIOD) begin
                        if (had) begin m_cur = mq.pop_front(); m_t = 0; end
                        else m_active = 0;
                    end
                end
                if (bus.in_valid && !full) mq.push_back(bus.in_data);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle compare against the model
    initial begin
        forever begin
            @(negedge clk);
            begin
                bit e_blank;
                int e_idx;
                int e_byte;
                e_blank = !m_active || (m_t >= 4 * H);
                e_idx   = (m_active && m_t < 4 * H) ? 3 - m_t / H : 0;
                e_byte  = (m_cur >> (8 * e_idx)) & 32'hFF;
                check("m_in_ready", bus.in_ready, mq.size() < D);
                check("m_busy",     bus.busy,     m_active || mq.size() != 0);
                check("m_blank",    bus.blank,    e_blank);
                check("m_overflow", bus.overflow, m_ovf);
                check("m_byte_idx", bus.byte_idx, e_idx);
                if (!e_blank) begin
                    check("m_hi", bus.hi_nibble, (e_byte >> 4) & 15);
                    check("m_lo", bus.lo_nibble, e_byte & 15);
                end
            end
        end
    end

    // Flags any appearance of the word dropped in the overflow test
    initial begin
        forever begin
            @(negedge clk);
            if (bus.blank === 1'b0 && bus.byte_idx === 2'd3 &&
                {bus.hi_nibble, bus.lo_nibble} === 8'hEE) seen_drop = 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (bus.busy !== 1'b0 && n < 200) begin tick(); n++; end
        check("drain_timeout", (n >= 200) ? 1 : 0, 0);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_in_ready"}, bus.in_ready,  1);
        check({tag, "_hi"},       bus.hi_nibble, 0);
        check({tag, "_lo"},       bus.lo_nibble, 0);
        check({tag, "_idx"},      bus.byte_idx,  0);
        check({tag, "_blank"},    bus.blank,     1);
        check({tag, "_busy"},     bus.busy,      0);
        check({tag, "_overflow"}, bus.overflow,  0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tests = 0; fails = 0; seen_drop = 0;
        rst = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;

        // 1. reset values
        #1 rst = 1'b1;
        #2 check_reset_vals("rst0");
        @(negedge clk); #2 rst = 1'b0;
        tick();

        // 2. single word, literal nibble sequence
        bus.in_valid = 1'b1; bus.in_data = 32'h12345678;
        tick();
        bus.in_valid = 1'b0;
        for (int k = 1; k <= 1 + PERIOD; k++) begin
            tick();
            if (k == 1) begin
                check("t2_b3_hi", bus.hi_nibble, 1); check("t2_b3_lo", bus.lo_nibble, 2);
                check("t2_b3_idx", bus.byte_idx, 3);
            end
            if (k == 3) begin check("t2_b2_hi", bus.hi_nibble, 3); check("t2_b2_lo", bus.lo_nibble, 4); end
            if (k == 5) begin check("t2_b1_hi", bus.hi_nibble, 5); check("t2_b1_lo", bus.lo_nibble, 6); end
            if (k == 8) begin check("t2_b0_hi", bus.hi_nibble, 7); check("t2_b0_lo", bus.lo_nibble, 8); end
            if (k == 9) check("t2_blank_after", bus.blank, 1);
            if (k == 1 + PERIOD) check("t2_busy_end", bus.busy, 0);
        end

        // 3. back-to-back words
        wait_idle();
        bus.in_valid = 1'b1; bus.in_data = 32'hAABBCCDD;
        tick();
        bus.in_data = 32'h01020304;
        tick();
        bus.in_valid = 1'b0;
        begin
            int nblank;
            nblank = 0;
            for (int k = 2; k <= 1 + PERIOD; k++) begin
                tick();
                if (k == 8) begin
                    check("t3_last_hi", bus.hi_nibble, 4'hD); check("t3_last_lo", bus.lo_nibble, 4'hD);
                end
                if (k > 8 && k <= PERIOD && bus.blank === 1'b1) nblank++;
                if (k == 1 + PERIOD) begin
                    check("t3_next_blank", bus.blank, 0);
                    check("t3_next_hi", bus.hi_nibble, 0); check("t3_next_lo", bus.lo_nibble, 1);
                end
            end
            check("t3_gap_cycles", nblank, PERIOD - 8);
        end

        // 4. fill and overflow
        wait_idle();
        seen_drop = 0;
        for (int i = 0; i < 6; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = (i == 5) ? 32'hEE00FF11 : {8'(8'h10 + i), 24'hABCDEF};
            tick();
            if (i == 4) check("t4_ready_low", bus.in_ready, 0);
        end
        bus.in_valid = 1'b0;
        check("t4_overflow", bus.overflow, 1);
        wait_idle();
        check("t4_dropped_never_shown", seen_drop, 0);

        // 5. push coincident with word-end pop at count 2
        bus.in_valid = 1'b1; bus.in_data = 32'hA1000000; tick();
        bus.in_data = 32'hB2000000; tick();
        bus.in_data = 32'hC3000000; tick();
        bus.in_valid = 1'b0;
        for (int k = 0; k < PERIOD - 2; k++) tick();
        bus.in_valid = 1'b1; bus.in_data = 32'hD4000000;
        tick();
        bus.in_valid = 1'b0;
        check("t5_ready", bus.in_ready, 1);
        check("t5_idx", bus.byte_idx, 3);
        check("t5_hi", bus.hi_nibble, 4'hB);
        check("t5_lo", bus.lo_nibble, 4'h2);
        wait_idle();

        // random traffic, light then heavy
        for (int c = 0; c < 500; c++) begin
            bus.in_valid = ($urandom_range(0, 99) < ((c < 250) ? 15 : 60));
            bus.in_data  = $urandom;
            tick();
        end
        bus.in_valid = 1'b0;
        wait_idle();

        // 6. reset mid-word with 3 words buffered
        bus.in_valid = 1'b1; bus.in_data = 32'h11223344; tick();
        bus.in_data = 32'h55667788; tick();
        bus.in_data = 32'h99AABBCC; tick();
        bus.in_data = 32'hDDEEFF00; tick();
        bus.in_valid = 1'b0;
        check("t6_idx_before", bus.byte_idx, 2);
        @(negedge clk); #1 rst = 1'b1;
        #1 check_reset_vals("rst_mid");
        @(negedge clk); #1 rst = 1'b0;
        check("t6_ready_after", bus.in_ready, 1);
        check("t6_busy_after", bus.busy, 0);
        begin
            int nb;
            nb = 0;
            for (int k = 0; k < 20; k++) begin
                tick();
                if (bus.blank === 1'b1 && bus.busy === 1'b0) nb++;
            end
            check("t6_stays_idle", nb, 20);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
